// File: rtl/uart_pkg.sv
// Shared constants and the stored-entry type for the UART receive FIFO.
// RX_FIFO_ERR_TAG_EN adds a per-entry error tag bit to the stored entry.
package uart_pkg;

  localparam int DEFAULT_DATA_BITS  = 8;
  localparam int DEFAULT_FIFO_WIDTH = 4;

`ifdef RX_FIFO_ERR_TAG_EN
  localparam int TAG_BITS = 1;

  typedef struct packed {
    logic                         err;
    logic [DEFAULT_DATA_BITS-1:0] data;
  } rx_entry_t;
`else
  localparam int TAG_BITS = 0;

  typedef struct packed {
    logic [DEFAULT_DATA_BITS-1:0] data;
  } rx_entry_t;
`endif

endpackage

// File: rtl/rx_fifo_mem.sv
// Storage array for rx_sync_fifo: one write port and one registered read port.
// The read register holds its value whenever rd_en is low.
module rx_fifo_mem #(
  parameter int WIDTH     = 9,
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [WIDTH-1:0]     rd_data
);

  logic [WIDTH-1:0] mem [2**ADDR_BITS];

  // NOTE: the array and its read register are deliberately left without reset so
  // they map onto plain RAM; the FIFO masks stale contents through its own state.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/rx_sync_fifo.sv
// Single-clock receive FIFO with occupancy count, status and sticky error flags.
// Define RX_FIFO_ERR_TAG_EN to store Rx_Err with each entry and return it on Err_Out.
module rx_sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEFAULT_DATA_BITS,
  parameter int FIFO_WIDTH = DEFAULT_FIFO_WIDTH,
  parameter int AF_LEVEL   = 2**(FIFO_WIDTH-1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_BITS-1:0]  Rx_Data,
  input  logic                  Rx_Err,
  input  logic                  Push,
  input  logic                  Pop,
  input  logic                  BIST_Mode,
  input  logic                  Clr_Err,
  output logic [DATA_BITS-1:0]  Data_Out,
  output logic                  Err_Out,
  output logic [FIFO_WIDTH:0]   Count,
  output logic                  FIFO_Empty,
  output logic                  FIFO_Full,
  output logic                  Almost_Full,
  output logic                  FIFO_Overflow,
  output logic                  FIFO_Underflow
);

  localparam int                 DEPTH      = 2**FIFO_WIDTH;
  localparam int                 ENTRY_BITS = DATA_BITS + TAG_BITS;
  localparam logic [FIFO_WIDTH:0]   FULL_CNT = DEPTH[FIFO_WIDTH:0];
  localparam logic [FIFO_WIDTH:0]   AF_CNT   = AF_LEVEL[FIFO_WIDTH:0];
  localparam logic [FIFO_WIDTH:0]   CNT_ONE  = 1;
  localparam logic [FIFO_WIDTH-1:0] PTR_ONE  = 1;

  logic [FIFO_WIDTH-1:0] wr_ptr;
  logic [FIFO_WIDTH-1:0] rd_ptr;
  logic [FIFO_WIDTH:0]   count_nxt;
  logic                  push_acc;
  logic                  pop_acc;
  logic                  ovf_set;
  logic                  udf_set;
  logic                  rd_loaded;
  logic [ENTRY_BITS-1:0] wr_entry;
  logic [ENTRY_BITS-1:0] rd_entry;

  assign pop_acc  = Pop  & ~BIST_Mode & (Count != '0);
  assign push_acc = Push & ~BIST_Mode & ((Count != FULL_CNT) | pop_acc);
  assign ovf_set  = Push & (Count == FULL_CNT) & ~pop_acc;
  assign udf_set  = Pop  & (Count == '0);

  // NOTE: every variable driven here gets a value before the case, so no latch can form.
  always_comb begin
    count_nxt = Count;
    case ({push_acc, pop_acc})
      2'b10:   count_nxt = Count + CNT_ONE;
      2'b01:   count_nxt = Count - CNT_ONE;
      default: count_nxt = Count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      Count          <= '0;
      FIFO_Empty     <= 1'b1;
      FIFO_Full      <= 1'b0;
      Almost_Full    <= 1'b0;
      FIFO_Overflow  <= 1'b0;
      FIFO_Underflow <= 1'b0;
      rd_loaded      <= 1'b0;
    end else if (!BIST_Mode) begin
      if (push_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_acc)  rd_ptr <= rd_ptr + PTR_ONE;
      if (pop_acc)  rd_loaded <= 1'b1;
      Count          <= count_nxt;
      FIFO_Empty     <= (count_nxt == '0);
      FIFO_Full      <= (count_nxt == FULL_CNT);
      Almost_Full    <= (count_nxt >= AF_CNT);
      // A set event in the same cycle as Clr_Err wins.
      FIFO_Overflow  <= ovf_set | (FIFO_Overflow  & ~Clr_Err);
      FIFO_Underflow <= udf_set | (FIFO_Underflow & ~Clr_Err);
    end
  end

  rx_fifo_mem #(
    .WIDTH     (ENTRY_BITS),
    .ADDR_BITS (FIFO_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push_acc),
    .wr_addr (wr_ptr),
    .wr_data (wr_entry),
    .rd_en   (pop_acc),
    .rd_addr (rd_ptr),
    .rd_data (rd_entry)
  );

  // The un-reset read register is gated to zero until the first pop after reset.
  assign Data_Out = rd_loaded ? rd_entry[DATA_BITS-1:0] : '0;

`ifdef RX_FIFO_ERR_TAG_EN
  assign wr_entry = {Rx_Err, Rx_Data};
  assign Err_Out  = rd_loaded & rd_entry[DATA_BITS];
`else
  logic unused_rx_err;
  assign unused_rx_err = Rx_Err;
  assign wr_entry      = Rx_Data;
  assign Err_Out       = 1'b0;
`endif

endmodule

// File: doc/rx_sync_fifo.md
RX_SYNC_FIFO -- requirements
Module: rx_sync_fifo

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning width of one data word.
REQ-002 SHALL have parameter FIFO_WIDTH, default 4, meaning log2 of depth; DEPTH = 2**FIFO_WIDTH entries.
REQ-003 SHALL have parameter AF_LEVEL, default 2**(FIFO_WIDTH-1), meaning almost-full threshold in entries (1..DEPTH).
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port Rx_Data, input, DATA_BITS, meaning write data.
REQ-007 SHALL have port Rx_Err, input, 1, meaning error tag travelling with Rx_Data.
REQ-008 SHALL have port Push, input, 1, meaning write request, sampled each clk.
REQ-009 SHALL have port Pop, input, 1, meaning read request, sampled each clk.
REQ-010 SHALL have port BIST_Mode, input, 1, meaning freeze all FIFO state.
REQ-011 SHALL have port Clr_Err, input, 1, meaning synchronous clear of sticky flags.
REQ-012 SHALL have port Data_Out, output, DATA_BITS, meaning registered read data.
REQ-013 SHALL have port Err_Out, output, 1, meaning registered error tag of Data_Out.
REQ-014 SHALL have port Count, output, FIFO_WIDTH+1, meaning current occupancy 0..DEPTH.
REQ-015 SHALL have ports FIFO_Empty, FIFO_Full, Almost_Full, FIFO_Overflow, FIFO_Underflow, each output, 1, meaning status flags.

Function
REQ-016 Push accepted when Push=1, BIST_Mode=0 and (Count<DEPTH or pop accepted same cycle); writes entry at write pointer, pointer +1.
REQ-017 Pop accepted when Pop=1, BIST_Mode=0 and Count>0; Data_Out/Err_Out load entry at read pointer on that edge (1-cycle latency), pointer +1.
REQ-018 Data_Out and Err_Out SHALL hold their value in every cycle without an accepted pop.
REQ-019 Simultaneous accepted push and pop: both performed, Count unchanged; at Count=0 only the push is performed; at Count=DEPTH both are performed.
REQ-020 Pointers are FIFO_WIDTH bits and wrap DEPTH-1 -> 0 without special handling.
REQ-021 Count: +1 on push only, -1 on pop only, otherwise unchanged; never exceeds DEPTH or goes below 0.
REQ-022 FIFO_Empty=(Count==0), FIFO_Full=(Count==DEPTH), Almost_Full=(Count>=AF_LEVEL); all registered, valid the cycle Count updates.
REQ-023 FIFO_Overflow set (sticky) when Push=1, Count==DEPTH, no accepted pop, BIST_Mode=0; rejected data discarded.
REQ-024 FIFO_Underflow set (sticky) when Pop=1, Count==0, BIST_Mode=0; Data_Out unchanged.
REQ-025 Clr_Err=1 clears both sticky flags next edge; a new set event the same cycle wins.
REQ-026 BIST_Mode=1: Push/Pop/Clr_Err ignored, all state and outputs hold.

Reset
REQ-027 rst_n=0 asynchronously: pointers 0, Count 0, Data_Out 0, Err_Out 0, FIFO_Empty 1, FIFO_Full 0, Almost_Full 0, FIFO_Overflow 0, FIFO_Underflow 0.
REQ-028 Storage array not reset; reset mid-operation discards all entries; first push after rst_n release is accepted normally.

Configuration
REQ-029 Macro RX_FIFO_ERR_TAG_EN defined: Rx_Err stored per entry (DATA_BITS+1 bit storage), Err_Out returns it.
REQ-030 Macro RX_FIFO_ERR_TAG_EN undefined: no tag storage, Rx_Err ignored, Err_Out tied 0; ports unchanged.

Structure
REQ-031 Shared package uart_pkg SHALL hold default DATA_BITS/FIFO_WIDTH constants and the stored-entry typedef (data + optional tag).
REQ-032 Storage SHALL be sub-module rx_fifo_mem (one write port, one registered read port, no reset); pointers, count, flags in rx_sync_fifo.

Verification
REQ-033 Reset, push 0x11,0x22,0x33, pop x3 -> Data_Out 0x11,0x22,0x33 one cycle after each pop; FIFO_Empty=1 after third.
REQ-034 Push 16 words (default params) -> Almost_Full=1 at Count=8, FIFO_Full=1 at 16; 17th push -> FIFO_Overflow=1, Count stays 16.
REQ-035 At Count=16 push 0xAA and pop same cycle -> Count 16, no overflow; 0xAA read out as 16th later pop (wrap verified).
REQ-036 Pop at Count=0 -> FIFO_Underflow=1, Data_Out unchanged; Clr_Err pulse -> both sticky flags 0.
REQ-037 BIST_Mode=1 with Push/Pop toggling 10 cycles -> Count, pointers, flags, Data_Out unchanged.
REQ-038 rst_n low mid-burst at Count=5 -> all outputs to reset values immediately, no clk edge needed; with RX_FIFO_ERR_TAG_EN push Rx_Err=1 -> Err_Out=1 on pop.
